// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core constants, fetch FSM states and next-pc select codes
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} fetch_state_t;
  typedef enum logic [1:0] {PC_KEEP, PC_INC, PC_TGT, PC_PEND} pc_sel_t;
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/pc_next.sv
// pc_next: combinational next fetch address select (hold / pc+4 / redirect target / pending target)
//   i_sel    select code
//   i_pc     current fetch address
//   i_target redirect target from the decoder (low bits masked here)
//   i_pend   pending target captured while a dropped fetch drains
//   o_pc     word-aligned next fetch address
module pc_next
  import riscv_pkg::*;
(
  input  pc_sel_t         i_sel,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_target,
  input  logic [XLEN-1:0] i_pend,
  output logic [XLEN-1:0] o_pc
);
  always_comb
    o_pc = word_align(i_sel == PC_INC  ? i_pc + 32'd4 :
                      i_sel == PC_TGT  ? i_target :
                      i_sel == PC_PEND ? i_pend : i_pc);
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage, one outstanding imem request, output hold register, branch redirect
//   clk, rst_n                 clock, synchronous active-low reset
//   imem_req/addr/ack/rdata    instruction memory req/ack handshake
//   instr_valid/instr/instr_pc fetched instruction to the decoder
//   instr_ready                decoder accepts the held instruction
//   redirect/redirect_target   taken branch (PcSrc) and its target
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_target
);
  fetch_state_t r_state, w_state_nxt;
  pc_sel_t      w_sel;
  logic [31:0]  r_pc, r_pend, r_instr, r_instr_pc, w_pc_nxt;
  logic         r_valid, w_fetch, w_drop, w_ack, w_load, w_pend_ld, w_squash;
  always_ff @(posedge clk)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state_nxt;
  // A redirect with no ack must not move imem_addr, so it parks in DROP until the stale ack drains.
  always_comb
    w_state_nxt = r_state == IDLE  ? FETCH :
                  r_state == FETCH ? (imem_ack ? (redirect ? FETCH : HOLD) : (redirect ? DROP : FETCH)) :
                  r_state == DROP  ? (imem_ack ? FETCH : DROP) :
                  (instr_ready | redirect) ? FETCH : HOLD;
  always_comb begin
    w_fetch   = r_state == FETCH;
    w_drop    = r_state == DROP;
    imem_req  = w_fetch | w_drop;
    w_ack     = imem_ack & imem_req;
    w_load    = w_fetch & imem_ack & !redirect;
    w_pend_ld = redirect & ((w_fetch & !imem_ack) | w_drop);
    w_squash  = r_state == HOLD & (instr_ready | redirect);
    // A redirect wins whenever pc is free to move: IDLE, any ack, or leaving HOLD.
    w_sel     = redirect & (r_state == IDLE | w_ack | w_squash) ? PC_TGT :
                w_load ? PC_INC :
                w_drop & imem_ack ? PC_PEND : PC_KEEP;
  end
  pc_next u_pc_next (
    .i_sel   (w_sel),
    .i_pc    (r_pc),
    .i_target(redirect_target),
    .i_pend  (r_pend),
    .o_pc    (w_pc_nxt)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_pend     <= '0;
      r_instr    <= INSTR_NOP;
      r_instr_pc <= RESET_PC;
      r_valid    <= 1'b0;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_pend_ld) r_pend <= word_align(redirect_target);
      if (w_load) begin
        r_instr    <= imem_rdata;
        r_instr_pc <= r_pc;
      end
      r_valid <= w_load ? 1'b1 : w_squash ? 1'b0 : r_valid;
    end
  assign imem_addr   = r_pc;
  assign instr_valid = r_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
module tb_fetch_unit;
  import riscv_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0, zw = 1'b0, ack_m = 1'b0;
  logic        instr_ready = 1'b1, redirect = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        imem_req, imem_ack, instr_valid;
  logic [31:0] imem_addr, imem_rdata, instr, instr_pc;
  int          tests = 0, fails = 0;
  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hA500_0013;
  endfunction
  assign imem_ack   = zw ? imem_req : ack_m;
  assign imem_rdata = word(imem_addr);
  always #5 clk = ~clk;
  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .redirect       (redirect),
    .redirect_target(redirect_target)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic fet(input string tag, input logic [31:0] a);
    chk({tag, "_req"}, {31'b0, imem_req}, 32'd1);
    chk({tag, "_addr"}, imem_addr, a);
    chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
  endtask
  task automatic hld(input string tag, input logic [31:0] a);
    chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
    chk({tag, "_instr"}, instr, word(a));
    chk({tag, "_pc"}, instr_pc, a);
    chk({tag, "_req"}, {31'b0, imem_req}, 32'd0);
  endtask
  initial begin
    step();
    step();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_ipc", instr_pc, 32'h0);
    rst_n = 1'b1;
    zw = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      fet("zw_fetch", 32'(4 * k));
      step();
      hld("zw_hold", 32'(4 * k));
      step();
    end
    zw = 1'b0;
    fet("lat_c1", 32'h10);
    step();
    fet("lat_c2", 32'h10);
    step();
    fet("lat_c3", 32'h10);
    ack_m = 1'b1;
    step();
    ack_m = 1'b0;
    hld("lat_hold", 32'h10);
    step();
    fet("lat_once", 32'h14);
    ack_m = 1'b1;
    step();
    ack_m = 1'b0;
    instr_ready = 1'b0;
    repeat (5) begin
      hld("bp_hold", 32'h14);
      step();
    end
    hld("bp_accept", 32'h14);
    instr_ready = 1'b1;
    step();
    fet("bp_resume", 32'h18);
    ack_m = 1'b1;
    redirect = 1'b1;
    redirect_target = 32'h10;
    step();
    fet("ack_redir", 32'h10);
    ack_m = 1'b0;
    redirect_target = 32'h103;
    step();
    redirect = 1'b0;
    fet("drop_wait1", 32'h10);
    step();
    fet("drop_wait2", 32'h10);
    ack_m = 1'b1;
    step();
    ack_m = 1'b0;
    fet("drop_done", 32'h100);
    chk("drop_ipc", instr_pc, 32'h14);
    ack_m = 1'b1;
    redirect = 1'b1;
    redirect_target = 32'h20;
    step();
    redirect = 1'b0;
    fet("to_20", 32'h20);
    step();
    ack_m = 1'b0;
    hld("hold_20", 32'h20);
    redirect = 1'b1;
    redirect_target = 32'h80;
    step();
    redirect = 1'b0;
    fet("acc_redir", 32'h80);
    ack_m = 1'b1;
    step();
    ack_m = 1'b0;
    hld("hold_80", 32'h80);
    instr_ready = 1'b0;
    redirect = 1'b1;
    redirect_target = 32'h40;
    step();
    redirect = 1'b0;
    instr_ready = 1'b1;
    fet("squash", 32'h40);
    redirect = 1'b1;
    redirect_target = 32'h200;
    step();
    redirect = 1'b0;
    fet("drop_pre_rst", 32'h40);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    ack_m = 1'b1;
    chk("drst_req", {31'b0, imem_req}, 32'd0);
    chk("drst_addr", imem_addr, 32'h0);
    step();
    fet("restart", 32'h0);
    chk("restart_instr", instr, 32'h0000_0013);
    redirect = 1'b1;
    redirect_target = 32'hFFFF_FFFF;
    step();
    redirect = 1'b0;
    fet("wrap_fetch", 32'hFFFF_FFFC);
    step();
    ack_m = 1'b0;
    hld("wrap_hold", 32'hFFFF_FFFC);
    step();
    fet("wrap_next", 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
